rtmq_cfg_loader: RTL and testbench

Upstream configuration front-end for the RTMQ core. Consumes a byte stream from the host link (UART receiver or equivalent) and does one of two things. It can assemble 32-bit instructions and inject them into the core through the configuration-override pair (`f_cfg`, `cfg_ins`). It can also bulk-write instruction words into the core's instruction block RAM through a simple write port. It holds the only state that turns raw host bytes into core-visible instructions.

---
 rtl/rtmq_cfg_loader_pkg.sv | 35 +++
 rtl/rtmq_byte_packer.sv | 47 ++++
 rtl/rtmq_cfg_loader.sv | 140 ++++++++++++++
 tb/tb_rtmq_cfg_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtmq_cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// rtmq_cfg_loader_pkg
// Shared constants and state encoding for the RTMQ configuration loader.
//   W_REG      : instruction / RAM word width (four host bytes)
//   W_CNT      : width of the burst word-count field
//   H_INJ_DEF  : default header byte for a direct-injection frame
//   H_WRM_DEF  : default header byte for an instruction-RAM write burst
//   state_t    : loader FSM states
//   takes_bytes: states in which the loader accepts host bytes
// -----------------------------------------------------------------------------
package rtmq_cfg_loader_pkg;

    localparam int         W_REG     = 32;
    localparam int         W_CNT     = 16;
    localparam logic [7:0] H_INJ_DEF = 8'hA5;
    localparam logic [7:0] H_WRM_DEF = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INJ   = 3'd1,
        S_ISSUE = 3'd2,
        S_GAP   = 3'd3,
        S_ADR   = 3'd4,
        S_CNT   = 3'd5,
        S_DAT   = 3'd6,
        S_WR    = 3'd7
    } state_t;

    // States that accept a host byte. The FSM stalls the link in all the others.
    function automatic logic takes_bytes(input state_t s);
        return (s == S_IDLE) || (s == S_INJ) || (s == S_ADR) ||
               (s == S_CNT)  || (s == S_DAT);
    endfunction

endpackage

// File: rtl/rtmq_byte_packer.sv
// -----------------------------------------------------------------------------
// rtmq_byte_packer
// Collects MSB-first host bytes into a word. It raises o_done on the cycle the
// last byte of a field (2 or 4 bytes) is taken, and o_word already contains that
// byte, so the consumer can latch the word on the same edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_take     : a byte is being consumed this cycle
//   i_len4     : 1 = 4-byte field, 0 = 2-byte field
//   i_byte     : byte being consumed
//   o_done     : the current byte completes the field
//   o_word     : {previous bytes, i_byte}, valid when o_done is high
// -----------------------------------------------------------------------------
module rtmq_byte_packer
    import rtmq_cfg_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_take,
    input  logic             i_len4,
    input  logic [7:0]       i_byte,
    output logic             o_done,
    output logic [W_REG-1:0] o_word
);

    logic [1:0]       r_cnt;
    logic [W_REG-9:0] r_sh;    // only the three older bytes need to be kept
    logic [1:0]       w_last;

    assign w_last = i_len4 ? 2'd3 : 2'd1;
    assign o_done = i_take && (r_cnt == w_last);
    assign o_word = {r_sh, i_byte};

    // NOTE: The shift register has a reset even though it is only datapath. A
    // reset in the middle of a field must not leave stale bytes behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_sh  <= '0;
        end else if (i_take) begin
            // NOTE: Sequential state is always assigned with <=. Every flop then
            // sees the values from before the edge, whatever the statement order.
            r_sh  <= {r_sh[W_REG-17:0], i_byte};
            r_cnt <= o_done ? 2'd0 : r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/rtmq_cfg_loader.sv
// -----------------------------------------------------------------------------
// rtmq_cfg_loader
// Turns a host byte stream into RTMQ instructions. A frame is either a direct
// injection (H_INJ + 4 bytes -> one f_cfg strobe, then N_GAP idle cycles) or an
// instruction-RAM burst (H_WRM + 2-byte address + 2-byte count + count*4 bytes).
// An unknown header byte is dropped and sets the sticky err flag.
//   clk, rst_n       : clock, asynchronous active-low reset
//   rx_dat/vld/rdy   : host byte stream, transfer on rx_vld & rx_rdy
//   f_cfg, cfg_ins   : one-cycle configuration-override strobe and instruction
//   mem_we/adr/dat   : instruction RAM write port
//   busy             : FSM is not idle
//   err              : unknown header seen since reset
// -----------------------------------------------------------------------------
module rtmq_cfg_loader
    import rtmq_cfg_loader_pkg::*;
#(
    parameter int         W_ADR = 12,
    parameter int         N_GAP = 4,
    parameter logic [7:0] H_INJ = H_INJ_DEF,
    parameter logic [7:0] H_WRM = H_WRM_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_dat,
    input  logic             rx_vld,
    output logic             rx_rdy,
    output logic             f_cfg,
    output logic [W_REG-1:0] cfg_ins,
    output logic             mem_we,
    output logic [W_ADR-1:0] mem_adr,
    output logic [W_REG-1:0] mem_dat,
    output logic             busy,
    output logic             err
);

    localparam int               W_GAP    = (N_GAP > 1) ? $clog2(N_GAP) : 1;
    localparam logic [W_GAP-1:0] GAP_LAST = W_GAP'((N_GAP > 0) ? N_GAP - 1 : 0);

    state_t             r_state, w_next;
    logic               r_rx_rdy, r_f_cfg, r_mem_we, r_err;
    logic [W_REG-1:0]   r_cfg_ins, r_mem_dat;
    logic [W_ADR-1:0]   r_mem_adr, r_adr;
    logic [W_CNT-1:0]   r_cnt;
    logic [W_GAP-1:0]   r_gap;

    logic               w_acc, w_take, w_len4, w_done, w_bad_hdr;
    logic [W_REG-1:0]   w_word;

    assign w_acc  = rx_vld && r_rx_rdy;
    // The header byte is consumed by the FSM itself. Only field bytes enter the packer.
    assign w_take = w_acc && (r_state != S_IDLE);
    assign w_len4 = (r_state == S_INJ) || (r_state == S_DAT);

    rtmq_byte_packer u_packer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_take (w_take),
        .i_len4 (w_len4),
        .i_byte (rx_dat),
        .o_done (w_done),
        .o_word (w_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: Every always_comb output gets a default first. A missed branch then
    // holds that default and cannot infer a latch.
    always_comb begin
        w_next    = r_state;
        w_bad_hdr = 1'b0;
        case (r_state)
            S_IDLE: if (w_acc) begin
                if      (rx_dat == H_INJ) w_next = S_INJ;
                else if (rx_dat == H_WRM) w_next = S_ADR;
                else                      w_bad_hdr = 1'b1;
            end
            S_INJ:   if (w_done) w_next = S_ISSUE;
            S_ISSUE: w_next = (N_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (r_gap == GAP_LAST) w_next = S_IDLE;
            S_ADR:   if (w_done) w_next = S_CNT;
            S_CNT:   if (w_done) w_next = (w_word[W_CNT-1:0] == '0) ? S_IDLE : S_DAT;
            S_DAT:   if (w_done) w_next = S_WR;
            // r_cnt still holds the count from before this write.
            S_WR:    w_next = (r_cnt == W_CNT'(1)) ? S_IDLE : S_DAT;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state they belong to. rx_rdy drops on the same edge that leaves a
    // byte-consuming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_rdy  <= 1'b0;
            r_f_cfg   <= 1'b0;
            r_cfg_ins <= '0;
            r_mem_we  <= 1'b0;
            r_mem_adr <= '0;
            r_mem_dat <= '0;
            r_adr     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rx_rdy <= takes_bytes(w_next);
            r_f_cfg  <= (w_next == S_ISSUE);
            r_mem_we <= (w_next == S_WR);

            if (r_state == S_INJ && w_done) r_cfg_ins <= w_word;
            if (r_state == S_ADR && w_done) r_adr     <= w_word[W_ADR-1:0];
            if (r_state == S_CNT && w_done) r_cnt     <= w_word[W_CNT-1:0];
            if (r_state == S_DAT && w_done) begin
                r_mem_dat <= w_word;
                r_mem_adr <= r_adr;
            end
            if (r_state == S_WR) begin
                r_adr <= r_adr + W_ADR'(1);   // wraps modulo 2^W_ADR
                r_cnt <= r_cnt - W_CNT'(1);
            end

            if (r_state == S_ISSUE)    r_gap <= '0;
            else if (r_state == S_GAP) r_gap <= r_gap + W_GAP'(1);

            if (w_bad_hdr) r_err <= 1'b1;
        end
    end

    assign rx_rdy  = r_rx_rdy;
    assign f_cfg   = r_f_cfg;
    assign cfg_ins = r_cfg_ins;
    assign mem_we  = r_mem_we;
    assign mem_adr = r_mem_adr;
    assign mem_dat = r_mem_dat;
    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;

endmodule

// File: tb/tb_rtmq_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_rtmq_cfg_loader
// Self-checking bench for rtmq_cfg_loader. Host bytes are driven with random
// rx_vld gaps. Injected instructions and RAM writes are captured into queues
// and compared with expectations built from frame contents.
// -----------------------------------------------------------------------------
module tb_rtmq_cfg_loader;

    localparam int W_ADR = 12;
    localparam int N_GAP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_dat = 8'h00;
    logic              rx_vld = 1'b0;
    logic              rx_rdy, f_cfg, mem_we, busy, err;
    logic [31:0]       cfg_ins, mem_dat;
    logic [W_ADR-1:0]  mem_adr;

    int vectors = 0;
    int miscompares = 0;
    int excl_viol = 0;

    logic [31:0]        obs_inj[$];
    logic [W_ADR+31:0]  obs_wr[$];

    rtmq_cfg_loader #(.W_ADR(W_ADR), .N_GAP(N_GAP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_dat  (rx_dat),
        .rx_vld  (rx_vld),
        .rx_rdy  (rx_rdy),
        .f_cfg   (f_cfg),
        .cfg_ins (cfg_ins),
        .mem_we  (mem_we),
        .mem_adr (mem_adr),
        .mem_dat (mem_dat),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Event capture on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_cfg)           obs_inj.push_back(cfg_ins);
            if (mem_we)          obs_wr.push_back({mem_adr, mem_dat});
            if (f_cfg && mem_we) excl_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge. Returns at the falling edge just after the byte
    // was transferred.
    task automatic send_byte(input logic [7:0] b);
        int budget;
        rx_vld = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_dat = b;
        rx_vld = 1'b1;
        budget = 0;
        while (rx_rdy !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (rx_rdy !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: byte %02h never accepted, rx_rdy=%b want 1", b, rx_rdy);
        end else begin
            @(negedge clk);
        end
        rx_vld = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    endtask

    task automatic send_inject(input logic [31:0] w);
        send_byte(8'hA5);
        send_word(w);
    endtask

    task automatic send_wr_hdr(input logic [15:0] adr, input logic [15:0] cnt);
        send_byte(8'h5A);
        send_byte(adr[15:8]); send_byte(adr[7:0]);
        send_byte(cnt[15:8]); send_byte(cnt[7:0]);
    endtask

    task automatic test_reset;
        logic [W_ADR+68:0] outs;
        idle(2);
        outs = {rx_rdy, f_cfg, cfg_ins, mem_we, mem_adr, mem_dat, busy, err};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want all zero", outs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (rx_rdy !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: rx_rdy=%b busy=%b want rx_rdy=1 busy=0", rx_rdy, busy);
        end
    endtask

    task automatic test_inject;
        int low;
        obs_inj.delete(); obs_wr.delete();
        send_inject(32'h12345678);
        vectors++;
        if (f_cfg !== 1'b1 || cfg_ins !== 32'h12345678) begin
            miscompares++;
            $display("FAIL inject_latency: f_cfg=%b cfg_ins=%h want 1 12345678", f_cfg, cfg_ins);
        end
        low = 0;
        while (rx_rdy === 1'b0 && low < 50) begin
            low++;
            @(negedge clk);
        end
        vectors++;
        if (low != N_GAP + 1) begin
            miscompares++;
            $display("FAIL inject_rdy_gap: rx_rdy low %0d cycles want %0d", low, N_GAP + 1);
        end
        idle(2);
        vectors++;
        if (obs_inj.size() != 1 || obs_wr.size() != 0) begin
            miscompares++;
            $display("FAIL inject_pulses: f_cfg pulses=%0d writes=%0d want 1 0", obs_inj.size(), obs_wr.size());
        end
    endtask

    task automatic test_write_burst;
        obs_inj.delete(); obs_wr.delete();
        send_wr_hdr(16'h0010, 16'd2);
        send_word(32'hDEADBEEF);
        vectors++;
        if (mem_we !== 1'b1 || mem_adr !== 12'h010 || mem_dat !== 32'hDEADBEEF || rx_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_w0: we=%b adr=%h dat=%h rdy=%b want 1 010 deadbeef 0", mem_we, mem_adr, mem_dat, rx_rdy);
        end
        send_word(32'hCAFEF00D);
        vectors++;
        if (mem_we !== 1'b1 || mem_adr !== 12'h011 || mem_dat !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL burst_w1: we=%b adr=%h dat=%h want 1 011 cafef00d", mem_we, mem_adr, mem_dat);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || mem_dat !== 32'hCAFEF00D || cfg_ins !== 32'h12345678) begin
            miscompares++;
            $display("FAIL burst_end: busy=%b we=%b dat=%h cfg_ins=%h want 0 0 cafef00d 12345678", busy, mem_we, mem_dat, cfg_ins);
        end
        idle(2);
        vectors++;
        if (obs_wr.size() != 2 || obs_inj.size() != 0) begin
            miscompares++;
            $display("FAIL burst_counts: writes=%0d f_cfg pulses=%0d want 2 0", obs_wr.size(), obs_inj.size());
        end
    endtask

    task automatic test_wrap;
        logic [31:0] w0, w1;
        logic [W_ADR+31:0] e0, e1;
        w0 = $urandom; w1 = $urandom;
        e0 = {12'hFFF, w0}; e1 = {12'h000, w1};
        obs_inj.delete(); obs_wr.delete();
        send_wr_hdr(16'h0FFF, 16'd2);
        send_word(w0);
        send_word(w1);
        idle(3);
        vectors++;
        if (obs_wr.size() != 2) begin
            miscompares++;
            $display("FAIL wrap_count: writes=%0d want 2", obs_wr.size());
        end else if (obs_wr[0] !== e0 || obs_wr[1] !== e1) begin
            miscompares++;
            $display("FAIL wrap_addr: got %h %h want %h %h", obs_wr[0], obs_wr[1], e0, e1);
        end
    endtask

    task automatic test_zero_count;
        logic [31:0] w;
        w = $urandom;
        obs_inj.delete(); obs_wr.delete();
        send_wr_hdr(16'h0020, 16'd0);
        vectors++;
        if (busy !== 1'b0 || rx_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_cnt_idle: busy=%b rdy=%b want 0 1", busy, rx_rdy);
        end
        send_inject(w);
        idle(N_GAP + 3);
        vectors++;
        if (obs_wr.size() != 0 || obs_inj.size() != 1) begin
            miscompares++;
            $display("FAIL zero_cnt_events: writes=%0d injections=%0d want 0 1", obs_wr.size(), obs_inj.size());
        end else if (obs_inj[0] !== w) begin
            miscompares++;
            $display("FAIL zero_cnt_inject: got %h want %h", obs_inj[0], w);
        end
    endtask

    task automatic test_bad_header;
        logic [31:0] w;
        w = $urandom;
        obs_inj.delete(); obs_wr.delete();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_initial: err=%b want 0", err);
        end
        send_byte(8'h3C);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_set: err=%b busy=%b want 1 0", err, busy);
        end
        send_inject(w);
        idle(N_GAP + 3);
        vectors++;
        if (obs_inj.size() != 1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_then_inject: injections=%0d err=%b want 1 1", obs_inj.size(), err);
        end else if (obs_inj[0] !== w) begin
            miscompares++;
            $display("FAIL err_inject_word: got %h want %h", obs_inj[0], w);
        end
    endtask

    task automatic test_reset_mid;
        logic [W_ADR+68:0] outs;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 rst_n = 1'b0;
        #1;
        outs = {rx_rdy, f_cfg, cfg_ins, mem_we, mem_adr, mem_dat, busy, err};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h want all zero", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        obs_inj.delete(); obs_wr.delete();
        @(negedge clk);
        send_inject(32'h11223344);
        vectors++;
        if (f_cfg !== 1'b1 || cfg_ins !== 32'h11223344) begin
            miscompares++;
            $display("FAIL reset_mid_inject: f_cfg=%b cfg_ins=%h want 1 11223344", f_cfg, cfg_ins);
        end
        idle(N_GAP + 3);
    endtask

    // Random frame mix. Expected events come from frame parameters: one word per
    // injection, and write i of a burst at (start + i) mod 2^W_ADR.
    task automatic test_random;
        logic [31:0]       exp_inj[$];
        logic [W_ADR+31:0] exp_wr[$];
        logic              exp_err;
        int                kind, cnt, bad;
        logic [15:0]       start;
        logic [31:0]       w;
        logic [7:0]        h;
        exp_err = 1'b0;
        obs_inj.delete(); obs_wr.delete();
        for (int f = 0; f < 16; f++) begin
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                h = 8'($urandom);
                while (h == 8'hA5 || h == 8'h5A) h = 8'($urandom);
                send_byte(h);
                exp_err = 1'b1;
            end else if (kind <= 3) begin
                w = $urandom;
                exp_inj.push_back(w);
                send_inject(w);
            end else begin
                start = 16'($urandom);
                cnt   = $urandom_range(0, 3);
                send_wr_hdr(start, 16'(cnt));
                for (int i = 0; i < cnt; i++) begin
                    w = $urandom;
                    exp_wr.push_back({W_ADR'((int'(start) + i) % (1 << W_ADR)), w});
                    send_word(w);
                end
            end
        end
        idle(N_GAP + 4);
        vectors++;
        if (obs_inj.size() != exp_inj.size() || obs_wr.size() != exp_wr.size()) begin
            miscompares++;
            $display("FAIL rand_counts: injections=%0d writes=%0d want %0d %0d",
                     obs_inj.size(), obs_wr.size(), exp_inj.size(), exp_wr.size());
        end else begin
            bad = 0;
            foreach (exp_inj[i]) if (obs_inj[i] !== exp_inj[i]) bad++;
            foreach (exp_wr[i])  if (obs_wr[i]  !== exp_wr[i])  bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL rand_events: %0d events differ from model, want 0", bad);
            end
        end
        vectors++;
        if (err !== exp_err || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_status: err=%b busy=%b want %b 0", err, busy, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_inject();
        test_write_burst();
        test_wrap();
        test_zero_count();
        test_bad_header();
        test_reset_mid();
        test_random();
        vectors++;
        if (excl_viol != 0) begin
            miscompares++;
            $display("FAIL cfg_we_exclusive: %0d cycles with f_cfg and mem_we both high, want 0", excl_viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
